// File: rtl/deconv_seq_ctrl.sv
// rtl/deconv_seq_ctrl.sv - job sequencer for one transposed-convolution engine.
// Optional WAIT_DONE watchdog enabled by defining DECONV_TIMEOUT_EN.
module deconv_seq_ctrl #(
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int PIXEL_BITS = 8,
    parameter int PIX_HOLD   = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K)-1:0]          cfg_stride,
    input  logic [$clog2(K*K)-1:0]        cfg_ksize,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic [PIXEL_BITS-1:0]         w_data,
    input  logic                          px_valid,
    output logic                          px_ready,
    input  logic [PIXEL_BITS-1:0]         px_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIXEL_BITS-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          job_done,
    output logic                          error,
    output logic                          eng_enable,
    output logic                          eng_strobe,
    output logic [PIXEL_BITS-1:0]         eng_kernel_weight,
    output logic [PIXEL_BITS-1:0]         eng_pixel,
    output logic [$clog2(K)-1:0]          eng_stride,
    output logic [$clog2(K*K)-1:0]        eng_number_weights,
    output logic [$clog2(N*N)-1:0]        eng_pixel_number,
    output logic [$clog2(N*N*K*K)-1:0]    eng_result_address,
    input  logic [PIXEL_BITS-1:0]         eng_final_output,
    input  logic                          eng_done
);

    localparam int SW  = $clog2(K);
    localparam int KW  = $clog2(K*K);
    localparam int PW  = $clog2(N*N);
    localparam int AW  = $clog2(N*N*K*K);
    localparam int HW  = $clog2(PIX_HOLD);
    localparam int WTW = 2*KW;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N*N*K*K-1);
    localparam logic [PW-1:0] LAST_PIX  = PW'(N*N-1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_LOAD_W    = 3'd2;
    localparam logic [2:0] S_PIX       = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_READOUT   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [WTW-1:0]        w_cnt_q, w_cnt_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [PW-1:0]         px_idx_q, px_idx_d;
    logic                  px_last_q, px_last_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic                  eng_enable_q, eng_enable_d;
    logic                  eng_strobe_q, eng_strobe_d;
    logic [PIXEL_BITS-1:0] eng_kernel_weight_q, eng_kernel_weight_d;
    logic [PIXEL_BITS-1:0] eng_pixel_q, eng_pixel_d;
    logic [SW-1:0]         eng_stride_q, eng_stride_d;
    logic [KW-1:0]         eng_number_weights_q, eng_number_weights_d;
    logic [PW-1:0]         eng_pixel_number_q, eng_pixel_number_d;
    logic                  job_done_q, job_done_d;
    logic [WTW-1:0]        w_total;

`ifdef DECONV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]         wd_q, wd_d;
    logic                  error_q, error_d;
`endif

    // The latched kernel side doubles as the weight-count limit.
    assign w_total = {{KW{1'b0}}, eng_number_weights_q} * {{KW{1'b0}}, eng_number_weights_q};

    assign busy      = (state_q != S_IDLE);
    assign w_ready   = (state_q == S_LOAD_W);
    assign px_ready  = (state_q == S_PIX) && (hold_q == '0) && !px_last_q;
    assign out_valid = (state_q == S_READOUT);
    assign out_data  = out_valid ? eng_final_output : '0;
    assign out_last  = out_valid && (rd_addr_q == LAST_ADDR);

    assign eng_enable         = eng_enable_q;
    assign eng_strobe         = eng_strobe_q;
    assign eng_kernel_weight  = eng_kernel_weight_q;
    assign eng_pixel          = eng_pixel_q;
    assign eng_stride         = eng_stride_q;
    assign eng_number_weights = eng_number_weights_q;
    assign eng_pixel_number   = eng_pixel_number_q;
    assign eng_result_address = rd_addr_q;
    assign job_done           = job_done_q;

`ifdef DECONV_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_d              = state_q;
        w_cnt_d              = w_cnt_q;
        hold_d               = hold_q;
        px_idx_d             = px_idx_q;
        px_last_d            = px_last_q;
        rd_addr_d            = rd_addr_q;
        eng_enable_d         = 1'b0;
        eng_strobe_d         = 1'b0;
        eng_kernel_weight_d  = eng_kernel_weight_q;
        eng_pixel_d          = eng_pixel_q;
        eng_stride_d         = eng_stride_q;
        eng_number_weights_d = eng_number_weights_q;
        eng_pixel_number_d   = eng_pixel_number_q;
        job_done_d           = 1'b0;
`ifdef DECONV_TIMEOUT_EN
        wd_d                 = '0;
        error_d              = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_ARM;
                    eng_enable_d = 1'b1;
                    eng_stride_d = cfg_stride;
                    if (cfg_ksize == '0 || cfg_ksize > KW'(K)) begin
                        eng_number_weights_d = KW'(K);
                    end else begin
                        eng_number_weights_d = cfg_ksize;
                    end
                    w_cnt_d   = '0;
                    hold_d    = '0;
                    px_idx_d  = '0;
                    px_last_d = 1'b0;
                    rd_addr_d = '0;
                end
            end
            S_ARM: begin
                state_d = S_LOAD_W;
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    eng_strobe_d        = 1'b1;
                    eng_kernel_weight_d = w_data;
                    if (w_cnt_q == w_total - WTW'(1)) begin
                        state_d = S_PIX;
                    end else begin
                        w_cnt_d = w_cnt_q + WTW'(1);
                    end
                end
            end
            S_PIX: begin
                // The hold counter covers the cycles after the load edge, so a
                // reload lands exactly PIX_HOLD cycles after the previous one.
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else if (px_last_q) begin
                    state_d = S_WAIT_DONE;
                end else if (px_valid) begin
                    eng_pixel_d        = px_data;
                    eng_pixel_number_d = px_idx_q;
                    hold_d             = HW'(PIX_HOLD-1);
                    if (px_idx_q == LAST_PIX) begin
                        px_last_d = 1'b1;
                    end else begin
                        px_idx_d = px_idx_q + PW'(1);
                    end
                end
            end
            S_WAIT_DONE: begin
                if (eng_done) begin
                    state_d = S_READOUT;
`ifdef DECONV_TIMEOUT_EN
                end else if (wd_q == TW'(TIMEOUT-1)) begin
                    error_d = 1'b1;
                    state_d = S_READOUT;
                end else begin
                    wd_d = wd_q + TW'(1);
`endif
                end
            end
            S_READOUT: begin
                if (out_ready) begin
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d    = S_IDLE;
                        job_done_d = 1'b1;
                        rd_addr_d  = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q              <= S_IDLE;
            w_cnt_q              <= '0;
            hold_q               <= '0;
            px_idx_q             <= '0;
            px_last_q            <= 1'b0;
            rd_addr_q            <= '0;
            eng_enable_q         <= 1'b0;
            eng_strobe_q         <= 1'b0;
            eng_kernel_weight_q  <= '0;
            eng_pixel_q          <= '0;
            eng_stride_q         <= '0;
            eng_number_weights_q <= '0;
            eng_pixel_number_q   <= '0;
            job_done_q           <= 1'b0;
`ifdef DECONV_TIMEOUT_EN
            wd_q                 <= '0;
            error_q              <= 1'b0;
`endif
        end else begin
            state_q              <= state_d;
            w_cnt_q              <= w_cnt_d;
            hold_q               <= hold_d;
            px_idx_q             <= px_idx_d;
            px_last_q            <= px_last_d;
            rd_addr_q            <= rd_addr_d;
            eng_enable_q         <= eng_enable_d;
            eng_strobe_q         <= eng_strobe_d;
            eng_kernel_weight_q  <= eng_kernel_weight_d;
            eng_pixel_q          <= eng_pixel_d;
            eng_stride_q         <= eng_stride_d;
            eng_number_weights_q <= eng_number_weights_d;
            eng_pixel_number_q   <= eng_pixel_number_d;
            job_done_q           <= job_done_d;
`ifdef DECONV_TIMEOUT_EN
            wd_q                 <= wd_d;
            error_q              <= error_d;
`endif
        end
    end

endmodule
